// File: rtl/systolic_seq_if.sv
// Control bus between the systolic-array sequencer and its buffers/array.
// master = sequencer side, slave = buffers / job issuer side.
interface systolic_seq_if #(
    parameter int SIZE    = 8,
    parameter int MAX_VEC = 256,
    parameter int VEC_W   = $clog2(MAX_VEC + 1),
    parameter int ADDR_W  = $clog2(MAX_VEC)
);
    localparam int WA_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic              start;
    logic [VEC_W-1:0]  num_vec;
    logic              reuse_w;
    logic [WA_W-1:0]   w_rd_addr;
    logic              pe_weight_valid;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_vec, reuse_w,
        output w_rd_addr, pe_weight_valid, act_rd_en, act_rd_addr,
               out_wr_en, out_wr_addr, busy, done
    );

    modport slave (
        output start, num_vec, reuse_w,
        input  w_rd_addr, pe_weight_valid, act_rd_en, act_rd_addr,
               out_wr_en, out_wr_addr, busy, done
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight preload,
// activation streaming, and write-back of deskewed result rows.
// Every output is a flop whose D input is derived from the next state,
// so the block is Moore with registered outputs.
module systolic_seq_ctrl #(
    parameter int SIZE     = 8,
    parameter int MAX_VEC  = 256,
    parameter int PIPE_LAT = 2 * SIZE,   // must be >= 1
    parameter int VEC_W    = $clog2(MAX_VEC + 1),
    parameter int ADDR_W   = $clog2(MAX_VEC)
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_seq_if.master        bus
);
    localparam int               WA_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [VEC_W-1:0] MAX_N = VEC_W'(MAX_VEC);

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [VEC_W-1:0]  n_lat, n_lat_d, n_in;
    logic [WA_W-1:0]   w_addr, w_addr_d;
    logic              pe_wv, pe_wv_d;
    logic              act_en, act_en_d;
    logic [ADDR_W-1:0] act_addr, act_addr_d;
    logic [VEC_W-1:0]  wr_cnt, wr_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PIPE_LAT-1:0] vld_pipe;
    logic              wr_en;

    // Last stage of the valid pipe is the write strobe itself, so the
    // strobe lands exactly PIPE_LAT cycles after the matching read.
    assign wr_en = vld_pipe[PIPE_LAT-1];

    // Oversized requests are clamped so counters never exceed MAX_VEC.
    always_comb n_in = (bus.num_vec > MAX_N) ? MAX_N : bus.num_vec;

    // Next-state, counter and output decode. reuse_w only steers the
    // branch taken on the accepting edge, so no stored copy is needed.
    always_comb begin
        state_d    = state;
        n_lat_d    = n_lat;
        w_addr_d   = w_addr;
        act_addr_d = act_addr;
        wr_cnt_d   = wr_en ? wr_cnt + VEC_W'(1) : wr_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    n_lat_d  = n_in;
                    wr_cnt_d = '0;
                    if (!bus.reuse_w) begin
                        state_d  = LOAD_W;
                        w_addr_d = WA_W'(SIZE - 1);
                    end else if (n_in != '0) begin
                        state_d    = COMPUTE;
                        act_addr_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD_W: begin
                // Bottom row first: it is shifted furthest down the array.
                if (w_addr == '0) begin
                    state_d    = (n_lat != '0) ? COMPUTE : DONE;
                    act_addr_d = '0;
                end else begin
                    w_addr_d = w_addr - WA_W'(1);
                end
            end
            COMPUTE: begin
                // Compare at VEC_W so N = MAX_VEC terminates without wrap.
                if (VEC_W'(act_addr) + VEC_W'(1) == n_lat) begin
                    state_d    = DRAIN;
                    act_addr_d = '0;
                end else begin
                    act_addr_d = act_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (wr_en && (wr_cnt + VEC_W'(1) == n_lat))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pe_wv_d  = (state_d == LOAD_W);
        act_en_d = (state_d == COMPUTE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_lat    <= '0;
            w_addr   <= '0;
            pe_wv    <= 1'b0;
            act_en   <= 1'b0;
            act_addr <= '0;
            wr_cnt   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            n_lat    <= n_lat_d;
            w_addr   <= w_addr_d;
            pe_wv    <= pe_wv_d;
            act_en   <= act_en_d;
            act_addr <= act_addr_d;
            wr_cnt   <= wr_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Valid shift register tracking reads in flight through array + deskew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= act_en;
            for (int i = 1; i < PIPE_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign bus.w_rd_addr       = w_addr;
    assign bus.pe_weight_valid = pe_wv;
    assign bus.act_rd_en       = act_en;
    assign bus.act_rd_addr     = act_addr;
    assign bus.out_wr_en       = wr_en;
    assign bus.out_wr_addr     = wr_cnt[ADDR_W-1:0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: stimulus pushes expected strobes
// (cycle, address) into per-kind queues; a negedge monitor pops and checks.
module tb_systolic_seq_ctrl;
    localparam int SIZE     = 8;
    localparam int MAX_VEC  = 256;
    localparam int PIPE_LAT = 16;
    localparam int VEC_W    = $clog2(MAX_VEC + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_seq_if #(.SIZE(SIZE), .MAX_VEC(MAX_VEC)) bus ();

    systolic_seq_ctrl #(.SIZE(SIZE), .MAX_VEC(MAX_VEC), .PIPE_LAT(PIPE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {int cyc; int addr;} exp_t;
    exp_t wq[$], aq[$], oq[$], dq[$];
    bit   busy_map[int];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_evt(input string nm, input bit have, input exp_t e, input int addr);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe at cycle %0d addr %0d", nm, cyc, addr);
        end else if (e.cyc != cyc || e.addr != addr) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d addr %0d, expected cycle %0d addr %0d",
                     nm, cyc, addr, e.cyc, e.addr);
        end
    endtask

    task automatic chk_zero(input string nm);
        logic [31:0] v;
        v = 32'({bus.w_rd_addr, bus.pe_weight_valid, bus.act_rd_en, bus.act_rd_addr,
                 bus.out_wr_en, bus.out_wr_addr, bus.busy, bus.done});
        n_tests++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs 0x%0h, expected 0", nm, v);
        end
    endtask

    // Monitor: every strobe must match the head of its queue; busy every cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   h;
        bit   eb;
        if (bus.pe_weight_valid) begin
            h = (wq.size() > 0); e = h ? wq.pop_front() : '{0, 0};
            chk_evt("weight", h, e, int'(bus.w_rd_addr));
        end
        if (bus.act_rd_en) begin
            h = (aq.size() > 0); e = h ? aq.pop_front() : '{0, 0};
            chk_evt("act_rd", h, e, int'(bus.act_rd_addr));
        end
        if (bus.out_wr_en) begin
            h = (oq.size() > 0); e = h ? oq.pop_front() : '{0, 0};
            chk_evt("out_wr", h, e, int'(bus.out_wr_addr));
        end
        if (bus.done) begin
            h = (dq.size() > 0); e = h ? dq.pop_front() : '{0, 0};
            chk_evt("done", h, e, 0);
        end
        eb = busy_map.exists(cyc);
        n_tests++;
        if (bus.busy !== eb) begin
            n_fail++;
            $display("FAIL busy: cycle %0d got %0b expected %0b", cyc, bus.busy, eb);
        end
    end

    // Expected strobes for a job whose start-sampling cycle is e (cycle 0).
    function automatic int push_job(input int e, input int n, input bit reuse);
        int off, dc;
        off = reuse ? 0 : SIZE;
        if (!reuse)
            for (int i = 0; i < SIZE; i++) wq.push_back('{e + 1 + i, SIZE - 1 - i});
        for (int k = 0; k < n; k++) begin
            aq.push_back('{e + off + 1 + k, k});
            oq.push_back('{e + off + 1 + k + PIPE_LAT, k});
        end
        dc = (n > 0) ? e + off + n + PIPE_LAT + 1 : e + off + 1;
        dq.push_back('{dc, 0});
        for (int c = e + 1; c <= dc; c++) busy_map[c] = 1'b1;
        return dc;
    endfunction

    task automatic run_job(input int n_in, input int n, input bit reuse);
        int e, dc;
        @(negedge clk);
        e  = cyc;
        dc = push_job(e, n, reuse);
        bus.start   = 1'b1;
        bus.num_vec = VEC_W'(n_in);
        bus.reuse_w = reuse;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc < dc + 2) @(negedge clk);
    endtask

    // start held high: the second job is sampled in the IDLE cycle 20.
    task automatic held_start();
        int e, dc;
        @(negedge clk);
        e  = cyc;
        dc = push_job(e, 2, 1'b1);
        dc = push_job(e + 20, 2, 1'b1);
        bus.start   = 1'b1;
        bus.num_vec = VEC_W'(2);
        bus.reuse_w = 1'b1;
        while (cyc < e + 21) @(negedge clk);
        bus.start = 1'b0;
        while (cyc < dc + 2) @(negedge clk);
    endtask

    // Asynchronous reset during COMPUTE of an N=10 job after five reads.
    task automatic abort_job();
        int e;
        @(negedge clk);
        e = cyc;
        for (int k = 0; k < 5; k++) aq.push_back('{e + 1 + k, k});
        for (int c = e + 1; c <= e + 5; c++) busy_map[c] = 1'b1;
        bus.start   = 1'b1;
        bus.num_vec = VEC_W'(10);
        bus.reuse_w = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc < e + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("abort_outputs");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic chk_empty(input string nm, input int sz);
        n_tests++;
        if (sz != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected strobes never seen, expected 0", nm, sz);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.num_vec = '0;
        bus.reuse_w = 1'b0;
        #12 chk_zero("reset_outputs");
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job(4, 4, 1'b0);       // full job with preload
        run_job(1, 1, 1'b1);       // weight reuse, single vector
        run_job(0, 0, 1'b1);       // empty job, done at cycle 1
        run_job(0, 0, 1'b0);       // empty job still refreshes weights
        run_job(256, 256, 1'b1);   // maximum job, reads overlap writes
        run_job(300, 256, 1'b1);   // oversized count clamps to MAX_VEC
        held_start();
        abort_job();
        run_job(3, 3, 1'b0);       // nominal timing after abort

        chk_empty("weight_left", wq.size());
        chk_empty("act_left", aq.size());
        chk_empty("wr_left", oq.size());
        chk_empty("done_left", dq.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the SIZE x SIZE weight-stationary RPE systolic array.
- Per job it runs three phases: preload one weight tile (array held in weight-shift mode), stream N activation vectors, then drain and write back N deskewed result rows.
- Drives buffer addresses/enables and the array-wide weight-valid line.
- Skew/deskew delay lines are outside this block.

Parameters:
- SIZE, 8, array dimension; also the number of weight rows per tile.
- MAX_VEC, 256, maximum activation vectors per job.
- PIPE_LAT, 2*SIZE, cycles from the act_rd_en cycle of vector k to the cycle its deskewed result row is valid at the array outputs; must be >= 1.
- VEC_W, $clog2(MAX_VEC+1), width of the vector-count input.
- ADDR_W, $clog2(MAX_VEC), width of the activation and result addresses.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, job request; sampled only in IDLE.
- num_vec, input, VEC_W, vector count N (0..MAX_VEC); latched on an accepted start.
- reuse_w, input, 1, latched on an accepted start; 1 skips the weight preload.
- w_rd_addr, output, $clog2(SIZE), weight-buffer row address (combinational-read buffer).
- pe_weight_valid, output, 1, broadcast to every RPE Weight_in_valid; 1 shifts weights down and freezes partial sums.
- act_rd_en, output, 1, activation-buffer read strobe.
- act_rd_addr, output, ADDR_W, activation vector index.
- out_wr_en, output, 1, result-buffer write strobe.
- out_wr_addr, output, ADDR_W, result row index.
- busy, output, 1, job in progress.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs 0. All counters and latched values 0. Reset mid-job aborts immediately with no further strobes.
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE. All outputs are registered (Moore).
- IDLE:
  - start=1 latches num_vec and reuse_w.
  - Next state is LOAD_W if reuse_w=0; else COMPUTE if N>0; else DONE.
  - start in any other state is ignored, including in DONE.
- LOAD_W: exactly SIZE cycles.
  - pe_weight_valid=1.
  - w_rd_addr = SIZE-1 down to 0, so the bottom-row weight enters first and ends at the bottom.
  - Then COMPUTE if N>0, else DONE.
  - pe_weight_valid is 0 in every other state.
- COMPUTE: exactly N cycles.
  - act_rd_en=1.
  - act_rd_addr = 0..N-1, incrementing by 1 per cycle.
  - Then DRAIN.
- Write-back:
  - Vector k's act_rd_en cycle is cycle c. In cycle c+PIPE_LAT, out_wr_en=1 and out_wr_addr=k.
  - Implement with a PIPE_LAT-deep valid shift register fed by act_rd_en plus a separate write counter; no per-entry address storage.
  - Write strobes may overlap COMPUTE when N > PIPE_LAT.
- DRAIN: stays until the cycle after the last write (index N-1), then DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every non-IDLE state, including DONE.
- Timing relative to the accepted start edge (cycle 0):
  - reuse_w=0: LOAD_W occupies cycles 1..SIZE; COMPUTE occupies SIZE+1..SIZE+N; writes occur at SIZE+1+PIPE_LAT .. SIZE+N+PIPE_LAT; done fires at SIZE+N+PIPE_LAT+1.
  - reuse_w=1: subtract SIZE from every value above.
- N=0:
  - reuse_w=0: LOAD_W still runs (weights are refreshed), then DONE; no activation or write strobes.
  - reuse_w=1: DONE in cycle 1.
- N=MAX_VEC: addresses reach MAX_VEC-1 without wrap. Counters are sized so that terminal compares never overflow.
- num_vec > MAX_VEC: clamp to MAX_VEC at latch time.
- Exactly N writes per job, each address written once, in ascending order.

Test Plan:
- SIZE=8, PIPE_LAT=16, start with N=4, reuse_w=0 -> pe_weight_valid at cycles 1-8 with w_rd_addr 7..0; act_rd_en at 9-12 with addr 0..3; out_wr_en at 25-28 with addr 0..3; done at 29; busy at 1-29.
- reuse_w=1, N=1 -> no weight strobes; act_rd_en at cycle 1 with addr 0; out_wr_en at 17 with addr 0; done at 18.
- N=0: reuse_w=1 -> done at cycle 1 with no other strobes. reuse_w=0 -> weight strobes at 1-8, done at 9.
- N=256, reuse_w=1 -> act addresses 0..255 at cycles 1-256; writes 0..255 at 17-272, overlapping reads for cycles 17-256; done at 273; exactly 256 writes.
- start held high continuously with N=2, reuse_w=1 -> second job accepted only in the IDLE cycle after done (cycle 20); no strobes are disturbed during the first job.
- rst asserted asynchronously mid-COMPUTE of an N=10 job -> all outputs 0 immediately and FSM in IDLE; no writes after release; a new job then runs with nominal timing.
